// File: rtl/light_pen_pkg.sv
// Shared types and constants for the light-pen matrix scanner.
package light_pen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        REPORT
    } state_t;

    localparam int N_ROWS    = 8;
    localparam int N_COLS    = 8;
    localparam int N_SAMPLES = 7;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'h01 << idx;
    endfunction

endpackage

// File: rtl/pen_sync.sv
// Two-flop synchronizer for the asynchronous photodiode comparator output.
module pen_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/light_pen_scanner.sv
// Lights the 8x8 matrix one pixel at a time, counts light-pen samples per
// pixel and reports {row, col, hit, count} to the display front-end.
//
// state  | meaning
// IDLE   | drives blank, waiting for enable
// SETTLE | pixel lit, letting the photodiode settle
// SAMPLE | pixel lit, accumulating synchronized pen samples
// REPORT | drives blank, publish result and advance pixel index
module light_pen_scanner
    import light_pen_pkg::*;
#(
    parameter int SETTLE_CYCLES = 200,
    parameter int HIT_THRESH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pen_i,
    output logic [7:0] row_drv_o,
    output logic [7:0] col_drv_o,
    output logic [7:0] addr_row,
    output logic [7:0] addr_col,
    output logic [3:0] led_data,
    output logic       data_valid,
    output logic       frame_done
);

    localparam int CW = ($clog2(SETTLE_CYCLES) < 3) ? 3 : $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LOAD = CW'(N_SAMPLES - 1);

    state_t        state;
    logic [2:0]    row_idx;
    logic [2:0]    col_idx;
    logic [CW-1:0] cnt;
    logic [2:0]    hits;
    logic          pen_s;

    logic [2:0]    row_next;
    logic [2:0]    col_next;
    logic          last_col;
    logic          last_pixel;

    pen_sync u_pen_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pen_i),
        .q     (pen_s)
    );

    // 3-bit indices wrap to 0 on their own after 7.
    assign last_col   = (col_idx == 3'(N_COLS - 1));
    assign last_pixel = last_col && (row_idx == 3'(N_ROWS - 1));
    assign col_next   = col_idx + 3'd1;
    assign row_next   = last_col ? row_idx + 3'd1 : row_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row_idx    <= 3'd0;
            col_idx    <= 3'd0;
            cnt        <= '0;
            hits       <= 3'd0;
            row_drv_o  <= 8'h00;
            col_drv_o  <= 8'h00;
            addr_row   <= 8'h01;
            addr_col   <= 8'h01;
            led_data   <= 4'h0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    row_drv_o <= 8'h00;
                    col_drv_o <= 8'h00;
                    if (enable) begin
                        row_drv_o <= onehot8(row_idx);
                        col_drv_o <= onehot8(col_idx);
                        cnt       <= SETTLE_LOAD;
                        hits      <= 3'd0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        cnt   <= SAMPLE_LOAD;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SAMPLE: begin
                    hits <= hits + {2'b00, pen_s};
                    if (cnt == '0) begin
                        row_drv_o <= 8'h00;
                        col_drv_o <= 8'h00;
                        state     <= REPORT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                REPORT: begin
                    addr_row   <= onehot8(row_idx);
                    addr_col   <= onehot8(col_idx);
                    led_data   <= {(hits >= 3'(HIT_THRESH)), hits};
                    data_valid <= 1'b1;
                    frame_done <= last_pixel;
                    row_idx    <= row_next;
                    col_idx    <= col_next;
                    // Enable is only consulted here, so a pixel is never cut short.
                    if (enable) begin
                        row_drv_o <= onehot8(row_next);
                        col_drv_o <= onehot8(col_next);
                        cnt       <= SETTLE_LOAD;
                        hits      <= 3'd0;
                        state     <= SETTLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_light_pen_scanner.sv
// Scoreboard bench for light_pen_scanner with SETTLE_CYCLES=4 (12-cycle pixel).
module tb_light_pen_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pen_i;
    logic [7:0] row_drv_o;
    logic [7:0] col_drv_o;
    logic [7:0] addr_row;
    logic [7:0] addr_col;
    logic [3:0] led_data;
    logic       data_valid;
    logic       frame_done;

    light_pen_scanner #(.SETTLE_CYCLES(4), .HIT_THRESH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pen_i      (pen_i),
        .row_drv_o  (row_drv_o),
        .col_drv_o  (col_drv_o),
        .addr_row   (addr_row),
        .addr_col   (addr_col),
        .led_data   (led_data),
        .data_valid (data_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] c;
        logic [3:0] led;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   phase = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-derived results for the pen patterns applied below.
    function automatic logic [3:0] led_for(input int r, input int c);
        if (r == 0 && c == 1) return 4'b0011;
        if (r == 0 && c == 2) return 4'b1100;
        if (r == 3 && c == 5) return 4'b1111;
        return 4'b0000;
    endfunction

    task automatic push_px(input int r, input int c);
        exp_t       e;
        logic [7:0] one;
        one   = 8'h01;
        e.r   = one << r;
        e.c   = one << c;
        e.led = led_for(r, c);
        e.fd  = (r == 7 && c == 7);
        q.push_back(e);
    endtask

    // Pen driver: phase is 1 on the first negedge the pixel is lit; a value set
    // at phase k is captured at the following posedge. Phases 3..5 land in
    // exactly three SAMPLE cycles after the 2-flop synchronizer.
    initial begin
        pen_i = 1'b0;
        forever begin
            @(negedge clk);
            if (row_drv_o == 8'h00) phase = 0;
            else phase++;
            pen_i = (row_drv_o == 8'h01 && col_drv_o == 8'h02 && phase >= 3 && phase <= 5) ||
                    (row_drv_o == 8'h01 && col_drv_o == 8'h04 && phase >= 3 && phase <= 6) ||
                    (row_drv_o == 8'h08 && col_drv_o == 8'h20);
        end
    end

    // Monitor: pops an expectation on every data_valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            total++;
            if (!((row_drv_o == 8'h00 && col_drv_o == 8'h00) ||
                  ($onehot(row_drv_o) && $onehot(col_drv_o)))) begin
                bad++;
                $display("FAIL drive_onehot: got row=%0h col=%0h", row_drv_o, col_drv_o);
            end
            if (data_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_report: got row=%0h col=%0h led=%0h expected none",
                             addr_row, addr_col, led_data);
                end else begin
                    e = q.pop_front();
                    chk("addr_row", 32'(addr_row), 32'(e.r));
                    chk("addr_col", 32'(addr_col), 32'(e.c));
                    chk("led_data", 32'(led_data), 32'(e.led));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                end
            end else if (frame_done) begin
                total++;
                bad++;
                $display("FAIL lone_frame_done: got 1 expected 0");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_addr_row", 32'(addr_row), 32'h01);
        chk("rst_addr_col", 32'(addr_col), 32'h01);
        chk("rst_led", 32'(led_data), 32'h0);
        chk("rst_row_drv", 32'(row_drv_o), 32'h0);
        chk("rst_col_drv", 32'(col_drv_o), 32'h0);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (data_valid || frame_done || row_drv_o != 0 || col_drv_o != 0) n++;
        end
        chk("idle_activity", 32'(n), 32'd0);

        // One full frame plus frame 2 up to pixel (2,3).
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                push_px(r, c);
        for (int i = 0; i < 20; i++)
            push_px(i / 8, i % 8);
        enable = 1'b1;

        t = 0;
        while (!frame_done && t < 1000) begin @(negedge clk); t++; end
        chk("frame_done_seen", 32'(frame_done), 32'd1);

        t = 0;
        while (!(row_drv_o == 8'h04 && col_drv_o == 8'h08) && t < 400) begin @(negedge clk); t++; end
        chk("reach_px_2_3", 32'(col_drv_o), 32'h08);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("drain_after_disable", 32'(q.size()), 32'd0);
        chk("idle_row_drv", 32'(row_drv_o), 32'h0);
        chk("idle_col_drv", 32'(col_drv_o), 32'h0);

        push_px(2, 4);
        enable = 1'b1;
        t = 0;
        while (!(row_drv_o == 8'h04 && col_drv_o == 8'h20) && t < 50) begin @(negedge clk); t++; end
        chk("reach_px_2_5", 32'(col_drv_o), 32'h20);
        t = 0;
        while (phase < 8 && t < 20) begin @(negedge clk); t++; end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr_row", 32'(addr_row), 32'h01);
        chk("mid_rst_addr_col", 32'(addr_col), 32'h01);
        chk("mid_rst_led", 32'(led_data), 32'h0);
        chk("mid_rst_row_drv", 32'(row_drv_o), 32'h0);
        chk("mid_rst_col_drv", 32'(col_drv_o), 32'h0);
        chk("mid_rst_valid", 32'(data_valid), 32'h0);
        chk("resume_report_seen", 32'(q.size()), 32'd0);
        reset = 1'b0;

        push_px(0, 0);
        push_px(0, 1);
        t = 0;
        while (!(row_drv_o == 8'h01 && col_drv_o == 8'h02) && t < 50) begin @(negedge clk); t++; end
        chk("restart_px_0_1", 32'(col_drv_o), 32'h02);
        enable = 1'b0;
        t = 0;
        while (q.size() != 0 && t < 50) begin @(negedge clk); t++; end
        chk("final_drain", 32'(q.size()), 32'd0);
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_pen_scanner.md
Name: light_pen_scanner

Overview:
Drives the 8x8 LED/photodiode matrix one pixel at a time and samples the light-pen photodiode while each pixel is lit. After each pixel it reports the pixel's one-hot row/column and a hit nibble on the addr_row/addr_col/led_data interface. The LCD display front-end consumes that interface, where led_data[3] selects the hit/no-hit glyph. This block is the producer side of that interface and sits between the matrix pins and the display front-end.

Parameters:
SETTLE_CYCLES, 200, cycles each pixel is lit before sampling starts; must be >= 2.
HIT_THRESH, 4, minimum pen-high sample count (out of 7) that flags a hit; range 1..7.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; scanning runs while high
pen_i  in  1  asynchronous photodiode comparator output, active-high
row_drv_o  out  8  one-hot row drive to the matrix; 0 means blank
col_drv_o  out  8  one-hot column drive to the matrix; 0 means blank
addr_row  out  8  one-hot row of the last reported pixel; held between reports
addr_col  out  8  one-hot column of the last reported pixel; held between reports
led_data  out  4  {hit, sample_count[2:0]} of the last reported pixel; held between reports
data_valid  out  1  one-cycle strobe when addr_row/addr_col/led_data update
frame_done  out  1  one-cycle strobe together with the report of pixel (7,7)

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on reset, and is checked before any other condition.
- Reset values:
  - state IDLE, row_idx=0, col_idx=0
  - row_drv_o=0, col_drv_o=0
  - addr_row=8'h01, addr_col=8'h01, led_data=4'h0
  - data_valid=0, frame_done=0, synchronizer flops=0, counters=0.
- pen_i passes through a 2-FF synchronizer. All counting uses the synchronized value pen_s.
- States:
  - IDLE: drives are 0. If enable=1, load row_drv_o=1<<row_idx and col_drv_o=1<<col_idx, clear cnt and hits, and go to SETTLE.
  - SETTLE: drives held. Stay exactly SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: drives held. Stay exactly 7 cycles. Each cycle, hits += pen_s. The 3-bit hits counter cannot overflow (maximum 7).
  - REPORT: lasts 1 cycle. Drives go to 0 for blanking.
    - Register addr_row=1<<row_idx, addr_col=1<<col_idx, led_data={hits>=HIT_THRESH, hits}.
    - Pulse data_valid.
    - Advance the index: col_idx+1. On col 7, wrap col_idx to 0 and increment row_idx.
    - If (row_idx,col_idx)=(7,7): wrap both to 0 and pulse frame_done in the same cycle as data_valid.
    - Next state: SETTLE with the new pixel's drives if enable=1, else IDLE.
- Pixel period with enable held = SETTLE_CYCLES+8 cycles. data_valid is spaced exactly that far apart.
- Drives are never active in more than one row or column at once. Drives are 0 in IDLE and REPORT.
- enable deasserted mid-pixel: the current pixel completes through REPORT, so there are no partial reports. The block then idles, and the next enable resumes at the next pixel index.
- Reset mid-operation: the next cycle shows reset values and no strobe. Scanning resumes from (0,0).
- addr_row and addr_col are always exactly one-hot, including after reset.

Decomposition:
- light_pen_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, REPORT}
  - N_ROWS=8, N_COLS=8, N_SAMPLES=7
  - a bin-to-onehot function.
- Sub-module pen_sync: a 2-FF synchronizer with synchronous reset, instantiated once for pen_i.

Test Plan:
(All scenarios use SETTLE_CYCLES=4, pixel period 12.)
1. Hold reset, then enable=0 for 50 cycles -> addr_row=addr_col=8'h01, led_data=0, drives=0, no strobes.
2. enable=1, pen_i=0 -> first data_valid with addr_row=8'h01, addr_col=8'h01, led_data=4'b0000. Then strobes every 12 cycles, with addr_col stepping 02,04,…,80 and then addr_row=02, addr_col=01.
3. pen_i = (row_drv_o==8'h08 && col_drv_o==8'h20) -> that report has led_data=4'b1111. All other reports have 4'b0000.
4. pen_i high for exactly 3 synchronized SAMPLE cycles -> led_data=4'b0011. With 4 cycles -> 4'b1100.
5. One full frame -> 64 data_valid pulses. frame_done coincides only with the report of 8'h80/8'h80, and the next report is 8'h01/8'h01.
6. Two interruptions:
   - Drop enable during SETTLE of pixel (2,3) -> report (row 8'h04, col 8'h08) still occurs, then drives stay 0. Re-enable -> the next report is col 8'h10.
   - Assert reset during SAMPLE -> reset values on the next cycle, and the next report is 8'h01/8'h01.
